// File: rtl/ram2_ctrl_if.sv
// CPU-side bundle between the IF/MEM stages and the RAM2 controller.
interface ram2_ctrl_if #(
    parameter int unsigned DATA_W = 16
);
    logic [15:0]       pc;
    logic [DATA_W-1:0] inst;
    logic              mem_ce;
    logic              mem_re;
    logic              mem_we;
    logic [15:0]       mem_addr_i;
    logic [DATA_W-1:0] mem_data_i;
    logic [DATA_W-1:0] mem_data_o;
    logic              stall_req;

    modport master (
        output pc, mem_ce, mem_re, mem_we, mem_addr_i, mem_data_i,
        input  inst, mem_data_o, stall_req
    );

    modport slave (
        input  pc, mem_ce, mem_re, mem_we, mem_addr_i, mem_data_i,
        output inst, mem_data_o, stall_req
    );
endinterface

// File: rtl/ram2_ctrl.sv
// RAM2 SRAM controller: fetches every cycle and stalls the pipeline for data accesses.
// Optional macro RAM2_TRACE_EN compiles in simulation-only access trace messages.
module ram2_ctrl #(
    parameter int unsigned ADDR_W   = 18,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned WR_PULSE = 2
) (
    input  logic              clk,
    input  logic              rst,
    ram2_ctrl_if.slave        cpu,
    output logic [ADDR_W-1:0] ram2_addr,
    inout  wire  [DATA_W-1:0] ram2_data,
    output logic              ram2_en_n,
    output logic              ram2_oe_n,
    output logic              ram2_we_n
);
    localparam int unsigned CNT_W = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WS,
        S_WP,
        S_WH,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   wcnt, wcnt_nxt;
    logic               drive;
    logic               stall_c;
    logic               fetch_ld;
    logic               rd_ld;
    logic               req_wr, req_rd;

    assign req_wr = cpu.mem_ce & cpu.mem_we;
    assign req_rd = cpu.mem_ce & cpu.mem_re & ~cpu.mem_we;

    // State, write-pulse counter and registered read results
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            wcnt           <= '0;
            cpu.inst       <= '0;
            cpu.mem_data_o <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            if (fetch_ld) cpu.inst       <= ram2_data;
            if (rd_ld)    cpu.mem_data_o <= ram2_data;
        end
    end

    // Next state and SRAM strobes; reset forces the bus idle in the same cycle
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        ram2_addr = ADDR_W'(cpu.pc);
        ram2_en_n = 1'b1;
        ram2_oe_n = 1'b1;
        ram2_we_n = 1'b1;
        drive     = 1'b0;
        stall_c   = 1'b0;
        fetch_ld  = 1'b0;
        rd_ld     = 1'b0;
        if (!rst) begin
            case (state)
                S_IDLE: begin
                    ram2_en_n = 1'b0;
                    ram2_oe_n = 1'b0;
                    if (req_wr) begin
                        stall_c   = 1'b1;
                        state_nxt = S_WS;
                    end else if (req_rd) begin
                        stall_c   = 1'b1;
                        state_nxt = S_RD;
                    end else begin
                        fetch_ld  = 1'b1;
                    end
                end
                S_RD: begin
                    ram2_addr = ADDR_W'(cpu.mem_addr_i);
                    ram2_en_n = 1'b0;
                    ram2_oe_n = 1'b0;
                    stall_c   = 1'b1;
                    rd_ld     = 1'b1;
                    state_nxt = S_DONE;
                end
                S_WS: begin
                    ram2_addr = ADDR_W'(cpu.mem_addr_i);
                    ram2_en_n = 1'b0;
                    drive     = 1'b1;
                    stall_c   = 1'b1;
                    wcnt_nxt  = '0;
                    state_nxt = S_WP;
                end
                S_WP: begin
                    ram2_addr = ADDR_W'(cpu.mem_addr_i);
                    ram2_en_n = 1'b0;
                    ram2_we_n = 1'b0;
                    drive     = 1'b1;
                    stall_c   = 1'b1;
                    if (wcnt == CNT_W'(WR_PULSE - 1)) state_nxt = S_WH;
                    else                              wcnt_nxt  = wcnt + CNT_W'(1);
                end
                S_WH: begin
                    ram2_addr = ADDR_W'(cpu.mem_addr_i);
                    ram2_en_n = 1'b0;
                    drive     = 1'b1;
                    stall_c   = 1'b1;
                    state_nxt = S_DONE;
                end
                S_DONE: begin
                    // Request still on the inputs was just served; fetch instead
                    ram2_en_n = 1'b0;
                    ram2_oe_n = 1'b0;
                    fetch_ld  = 1'b1;
                    state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign cpu.stall_req = stall_c;
    assign ram2_data     = drive ? cpu.mem_data_i : {DATA_W{1'bz}};

`ifdef RAM2_TRACE_EN
    always_ff @(posedge clk) begin
        if (!rst && state == S_RD)
            $display("ram2 rd addr %h data %h", ram2_addr, ram2_data);
        if (!rst && state == S_WH)
            $display("ram2 wr addr %h data %h", ram2_addr, ram2_data);
    end
`endif

endmodule
